// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if -- memory bus between the load/store unit and the data memory.
//
// Signals:
//   bus_req    master -> slave  transaction in progress
//   bus_we     master -> slave  1 = store, 0 = load
//   bus_addr   master -> slave  word-aligned byte address (bits [1:0] = 00)
//   bus_be     master -> slave  byte enables, bit k = byte lane k (little-endian)
//   bus_wdata  master -> slave  store data, already replicated onto the lanes
//   bus_rdata  slave -> master  load data, valid while bus_ack is high
//   bus_ack    slave -> master  one-cycle completion pulse
//
// Modports: master (load/store unit side), slave (memory side).

interface lsu_ctrl_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store unit controller between the datapath and the memory bus.
//
// Turns a datapath load/store request into a single bus transaction, stalls the
// pipeline while it is outstanding, extracts and extends load data, checks
// alignment and aborts a transaction the bus never acknowledges.
//
// Parameters:
//   TIMEOUT       bus wait cycles before abort (1..255)
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   memread       load request (held while stall is high)
//   memwrite      store request (held while stall is high)
//   size          00 byte, 01 half, 10/11 word
//   lsu_unsigned  1 = zero-extend loads, 0 = sign-extend
//   addr, wdata   byte address and store data
//   readdata      load result, valid in the DONE cycle
//   stall         freeze PC and register write
//   misalign      combinational: the current request is misaligned
//   err           sticky misalign/timeout flag
//   bus           memory bus, master side

module lsu_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               memread,
   input  logic               memwrite,
   input  logic [1:0]         size,
   input  logic               lsu_unsigned,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic [31:0]        readdata,
   output logic               stall,
   output logic               misalign,
   output logic               err,
   lsu_ctrl_if.master         bus
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic        req_active;
   logic        aligned;
   logic        start;
   logic        timeout_hit;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic        uns_q;
   logic [7:0]  wait_cnt;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;

   // Alignment check, byte-enable pattern and store-lane replication for the
   // incoming request. Replicating narrow stores onto every lane lets the
   // memory pick the data purely from bus_be.
   always_comb begin
      aligned = 1'b1;
      be_d    = 4'b1111;
      wdata_d = wdata;
      case (size)
         2'b00: begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
         end
         2'b01: begin
            aligned = ~addr[0];
            be_d    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata[15:0]}};
         end
         default: begin
            aligned = (addr[1:0] == 2'b00);
            be_d    = 4'b1111;
            wdata_d = wdata;
         end
      endcase
   end

   assign req_active  = memread | memwrite;
   assign misalign    = req_active & ~aligned;
   assign start       = (state_q == IDLE) & req_active & aligned;
   assign stall       = (state_q == BUSY) | start;
   assign bus.bus_req = (state_q == BUSY);

   // The abort fires on the cycle whose increment would reach TIMEOUT, so a
   // never-acknowledged access spends exactly TIMEOUT cycles in BUSY.
   // An ack in the same cycle takes priority.
   assign timeout_hit = (state_q == BUSY) & ~bus.bus_ack
                        & ((wait_cnt + 8'd1) == TIMEOUT_CNT);

   // Load lane extraction and extension, using the lane/size captured when
   // the transaction started rather than the live datapath inputs.
   always_comb begin
      load_byte = bus.bus_rdata[7:0];
      case (off_q)
         2'd0:    load_byte = bus.bus_rdata[7:0];
         2'd1:    load_byte = bus.bus_rdata[15:8];
         2'd2:    load_byte = bus.bus_rdata[23:16];
         default: load_byte = bus.bus_rdata[31:24];
      endcase
      load_half = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      case (size_q)
         2'b00:   load_data = uns_q ? {24'd0, load_byte}
                                    : {{24{load_byte[7]}}, load_byte};
         2'b01:   load_data = uns_q ? {16'd0, load_half}
                                    : {{16{load_half[15]}}, load_half};
         default: load_data = bus.bus_rdata;
      endcase
   end

   // Next-state logic: DONE always lasts exactly one cycle so the datapath
   // sees readdata for one cycle with stall low.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = BUSY;
         BUSY:    if (bus.bus_ack || timeout_hit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Bus request capture, wait counter, load result and sticky error.
   // Bus outputs are only loaded on BUSY entry, which keeps them stable for
   // the whole transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.bus_addr  <= 32'd0;
         bus.bus_be    <= 4'd0;
         bus.bus_we    <= 1'b0;
         bus.bus_wdata <= 32'd0;
         size_q        <= 2'd0;
         off_q         <= 2'd0;
         uns_q         <= 1'b0;
         wait_cnt      <= 8'd0;
         readdata      <= 32'd0;
         err           <= 1'b0;
      end else begin
         if (misalign) err <= 1'b1;
         if ((state_q == IDLE) && misalign) readdata <= 32'd0;
         if (start) begin
            bus.bus_addr  <= {addr[31:2], 2'b00};
            bus.bus_be    <= be_d;
            bus.bus_we    <= memwrite;
            bus.bus_wdata <= wdata_d;
            size_q        <= size;
            off_q         <= addr[1:0];
            uns_q         <= lsu_unsigned;
            wait_cnt      <= 8'd0;
         end
         if (state_q == BUSY) begin
            if (bus.bus_ack) begin
               if (!bus.bus_we) readdata <= load_data;
            end else begin
               wait_cnt <= wait_cnt + 8'd1;
               if (timeout_hit) begin
                  readdata <= 32'd0;
                  err      <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- scoreboard bench for lsu_ctrl.
//
// Each directed access pushes its expected bus transaction and its expected
// completion result into two queues. A bus monitor pops on every rising
// bus_req and checks the bus fields for as long as bus_req stays high; a
// completion monitor pops when stall falls (the DONE cycle) and checks
// readdata and err. A behavioural memory slave answers after a programmable
// number of wait cycles or never.

module tb_lsu_ctrl;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } bus_exp_t;

   typedef struct packed {
      logic        chk_rd;
      logic [31:0] rd;
      logic        err;
   } done_exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        memread, memwrite, lsu_unsigned;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [31:0] readdata;
   logic        stall, misalign, err;

   lsu_ctrl_if mem_bus ();

   lsu_ctrl #(.TIMEOUT(15)) dut (
      .clk          (clk),
      .reset        (reset),
      .memread      (memread),
      .memwrite     (memwrite),
      .size         (size),
      .lsu_unsigned (lsu_unsigned),
      .addr         (addr),
      .wdata        (wdata),
      .readdata     (readdata),
      .stall        (stall),
      .misalign     (misalign),
      .err          (err),
      .bus          (mem_bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   bus_exp_t    bus_q[$];
   done_exp_t   done_q[$];
   int          slave_wait = 0;
   logic [31:0] slave_rdata = 32'd0;
   logic        force_ack = 1'b0;

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory slave: acks after slave_wait cycles of bus_req, never if negative.
   // force_ack produces a stray ack regardless of bus_req.
   initial begin
      int wcnt;
      wcnt = 0;
      mem_bus.bus_ack   = 1'b0;
      mem_bus.bus_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #2;
         mem_bus.bus_ack = 1'b0;
         if (force_ack) begin
            mem_bus.bus_ack   = 1'b1;
            mem_bus.bus_rdata = 32'hDEADBEEF;
         end else if (mem_bus.bus_req && slave_wait >= 0) begin
            if (wcnt == slave_wait) begin
               mem_bus.bus_ack   = 1'b1;
               mem_bus.bus_rdata = slave_rdata;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Bus monitor.
   initial begin
      logic     prev_req;
      logic     have_cur;
      bus_exp_t cur;
      prev_req = 1'b0;
      have_cur = 1'b0;
      cur      = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_req = 1'b0;
            have_cur = 1'b0;
         end else begin
            if (mem_bus.bus_req && !prev_req) begin
               if (bus_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("[TB] FAIL unexpected_bus_cycle: got bus_req=1, expected 0 at %0t", $time);
                  have_cur = 1'b0;
               end else begin
                  cur      = bus_q.pop_front();
                  have_cur = 1'b1;
               end
            end
            if (mem_bus.bus_req && have_cur) begin
               check_output("bus_addr",  mem_bus.bus_addr,  cur.addr);
               check_output("bus_be",    32'(mem_bus.bus_be), 32'(cur.be));
               check_output("bus_wdata", mem_bus.bus_wdata, cur.wdata);
               check_output("bus_we",    32'(mem_bus.bus_we), 32'(cur.we));
            end
            prev_req = mem_bus.bus_req;
         end
      end
   end

   // Completion monitor: the DONE cycle is the first stall-low cycle after a
   // run of stall-high cycles.
   initial begin
      logic      prev_stall;
      done_exp_t e;
      prev_stall = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && !stall) begin
               if (done_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("[TB] FAIL unexpected_done: got completion, expected none at %0t", $time);
               end else begin
                  e = done_q.pop_front();
                  if (e.chk_rd) check_output("readdata", readdata, e.rd);
                  check_output("done_err", 32'(err), 32'(e.err));
               end
            end
            prev_stall = stall;
         end
      end
   end

   task automatic apply_stimulus(input logic is_wr, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rdat,
                                 input int wt, input logic [31:0] e_addr,
                                 input logic [3:0] e_be, input logic [31:0] e_wdata,
                                 input logic [31:0] e_rd, input logic e_err,
                                 input int e_stall);
      int n;
      bus_q.push_back('{addr: e_addr, be: e_be, wdata: e_wdata, we: is_wr});
      done_q.push_back('{chk_rd: !is_wr, rd: e_rd, err: e_err});
      slave_rdata = rdat;
      slave_wait  = wt;
      @(posedge clk);
      #1;
      memread      = !is_wr;
      memwrite     = is_wr;
      size         = sz;
      lsu_unsigned = uns;
      addr         = a;
      wdata        = wd;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (stall) n++;
         else break;
      end
      check_output("stall_cycles", 32'(n), 32'(e_stall));
      @(posedge clk);
      #1;
      memread  = 1'b0;
      memwrite = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no end of test, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1;
      memread = 1'b0; memwrite = 1'b0; lsu_unsigned = 1'b0;
      size = 2'b10; addr = 32'd0; wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_readdata", readdata, 32'd0);
      check_output("rst_err",      32'(err), 32'd0);
      check_output("rst_stall",    32'(stall), 32'd0);
      check_output("rst_bus_req",  32'(mem_bus.bus_req), 32'd0);
      check_output("rst_bus_be",   32'(mem_bus.bus_be), 32'd0);
      check_output("rst_bus_addr", mem_bus.bus_addr, 32'd0);
      check_output("rst_bus_we",   32'(mem_bus.bus_we), 32'd0);
      reset = 1'b0;

      // Word load, 2 wait cycles.
      apply_stimulus(0, 2'b10, 0, 32'h100, 32'h0, 32'h8899AABB, 2,
                     32'h100, 4'b1111, 32'h0, 32'h8899AABB, 0, 4);
      // Byte load lane 3, signed then unsigned.
      apply_stimulus(0, 2'b00, 0, 32'h103, 32'h0, 32'h80FF0000, 0,
                     32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 0, 2);
      apply_stimulus(0, 2'b00, 1, 32'h103, 32'h0, 32'h80FF0000, 0,
                     32'h100, 4'b1000, 32'h0, 32'h00000080, 0, 2);
      // Byte load lane 1, unsigned.
      apply_stimulus(0, 2'b00, 1, 32'h101, 32'h0, 32'h0000C300, 0,
                     32'h100, 4'b0010, 32'h0, 32'h000000C3, 0, 2);
      // Byte store lane 2.
      apply_stimulus(1, 2'b00, 0, 32'h002, 32'h00000055, 32'h0, 0,
                     32'h000, 4'b0100, 32'h55555555, 32'h0, 0, 2);
      // No ack: abort after 15 BUSY cycles.
      apply_stimulus(0, 2'b10, 0, 32'h040, 32'h0, 32'h0, -1,
                     32'h040, 4'b1111, 32'h0, 32'h0, 1, 16);

      // Reset in the second BUSY cycle.
      bus_q.push_back('{addr: 32'h200, be: 4'b1111, wdata: 32'h0, we: 1'b0});
      slave_wait = -1;
      @(posedge clk);
      #1;
      memread = 1'b1; size = 2'b10; addr = 32'h200; wdata = 32'h0;
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      memread = 1'b0;
      #1;
      check_output("async_bus_req", 32'(mem_bus.bus_req), 32'd0);
      check_output("async_stall",   32'(stall), 32'd0);
      check_output("async_err",     32'(err), 32'd0);
      check_output("async_bus_be",  32'(mem_bus.bus_be), 32'd0);
      check_output("async_addr",    mem_bus.bus_addr, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      force_ack = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      force_ack = 1'b0;
      check_output("late_ack_req",      32'(mem_bus.bus_req), 32'd0);
      check_output("late_ack_stall",    32'(stall), 32'd0);
      check_output("late_ack_readdata", readdata, 32'd0);

      // Fresh access after reset: half load upper lane, signed.
      apply_stimulus(0, 2'b01, 0, 32'h106, 32'h0, 32'h9ABC1234, 1,
                     32'h104, 4'b1100, 32'h0, 32'hFFFF9ABC, 0, 3);
      // Half store upper lane.
      apply_stimulus(1, 2'b01, 0, 32'h022, 32'h1234ABCD, 32'h0, 1,
                     32'h020, 4'b1100, 32'hABCDABCD, 32'h0, 0, 3);

      // Misaligned word load.
      @(posedge clk);
      #1;
      memread = 1'b1; size = 2'b10; addr = 32'h102; lsu_unsigned = 1'b0;
      @(negedge clk);
      check_output("mis_flag",    32'(misalign), 32'd1);
      check_output("mis_stall",   32'(stall), 32'd0);
      check_output("mis_bus_req", 32'(mem_bus.bus_req), 32'd0);
      check_output("mis_err_pre", 32'(err), 32'd0);
      @(negedge clk);
      check_output("mis_err",      32'(err), 32'd1);
      check_output("mis_readdata", readdata, 32'd0);
      check_output("mis_stall2",   32'(stall), 32'd0);
      @(posedge clk);
      #1;
      memread = 1'b0; memwrite = 1'b1; size = 2'b01; addr = 32'h101;
      #1;
      check_output("mis_half_flag", 32'(misalign), 32'd1);
      memwrite = 1'b0; memread = 1'b1; size = 2'b00; addr = 32'h103;
      #1;
      check_output("byte_aligned_flag", 32'(misalign), 32'd0);
      memread = 1'b0;
      @(negedge clk);
      check_output("err_sticky", 32'(err), 32'd1);

      repeat (3) @(negedge clk);
      check_output("bus_q_empty",  32'(bus_q.size()), 32'd0);
      check_output("done_q_empty", 32'(done_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
